if_fetch_unit: RTL and testbench

- Instruction-fetch stage that produces the IF-side inputs of the IF/ID pipeline register: if_pc, if_pc4 and if_inst, plus a valid flag.
- Owns the program counter.
- Runs a single-outstanding req/ack handshake to instruction memory.
- Honours the hazard-unit stall and the EX-stage branch/jump redirect.
- Sits between imem and the IF/ID register.

---
 rtl/if_fetch_unit_if.sv | 11 +
 rtl/if_fetch_unit.sv | 130 +++++++++++++
 tb/tb_if_fetch_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// One request outstanding at a time; addr is held stable while req is high.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake and produces
// the registered IF-side inputs of the IF/ID register, honouring stall and redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  if_fetch_unit_if.master       imem,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_pc4,
  output logic [31:0]           if_inst,
  output logic                  if_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_q, fetch_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] skid_inst_q, skid_inst_d;
  logic [XLEN-1:0] skid_addr_q, skid_addr_d;
  logic [XLEN-1:0] pc_d, pc4_d, inst_d;
  logic            valid_d;
  logic [XLEN-1:0] target;
  logic            unused_ok;

  assign target    = {redirect_pc[31:2], 2'b00};
  assign unused_ok = ^redirect_pc[1:0];

  // Request is decoded from state; HOLD has nothing in flight
  assign imem.req  = !rst && (state_q != HOLD);
  assign imem.addr = fetch_q;

  always_comb begin
    state_d     = state_q;
    fetch_d     = fetch_q;
    pend_d      = pend_q;
    skid_inst_d = skid_inst_q;
    skid_addr_d = skid_addr_q;
    pc_d        = if_pc;
    pc4_d       = if_pc4;
    inst_d      = if_inst;
    valid_d     = if_valid;

    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          if (imem.ack) begin
            fetch_d = target;
          end else begin
            pend_d  = target;
            state_d = DROP;
          end
        end else if (imem.ack && !stall) begin
          pc_d    = fetch_q;
          pc4_d   = XLEN'(fetch_q + 32'd4);
          inst_d  = imem.rdata;
          valid_d = 1'b1;
          fetch_d = XLEN'(fetch_q + 32'd4);
        end else if (imem.ack) begin
          skid_inst_d = imem.rdata;
          skid_addr_d = fetch_q;
          fetch_d     = XLEN'(fetch_q + 32'd4);
          state_d     = HOLD;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          fetch_d = target;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = skid_addr_q;
          pc4_d   = XLEN'(skid_addr_q + 32'd4);
          inst_d  = skid_inst_q;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end
      DROP: begin
        // Wait out the stale request; the newest redirect target wins
        valid_d = 1'b0;
        if (redirect_valid) begin
          pend_d = target;
        end
        if (imem.ack) begin
          fetch_d = redirect_valid ? target : pend_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      fetch_q     <= RESET_PC;
      pend_q      <= RESET_PC;
      skid_inst_q <= NOP_INST;
      skid_addr_q <= '0;
      if_pc       <= '0;
      if_pc4      <= '0;
      if_inst     <= NOP_INST;
      if_valid    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_q     <= fetch_d;
      pend_q      <= pend_d;
      skid_inst_q <= skid_inst_d;
      skid_addr_q <= skid_addr_d;
      if_pc       <= pc_d;
      if_pc4      <= pc4_d;
      if_inst     <= inst_d;
      if_valid    <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table against a
// variable-latency imem responder returning 0xA0 + addr.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] if_pc, if_pc4, if_inst;
  logic        if_valid;

  int lat = 1;
  int cnt = 0;
  int n_chk = 0;
  int n_fail = 0;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0100), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4),
    .if_inst        (if_inst),
    .if_valid       (if_valid)
  );

  always #5 clk = ~clk;

  // Responder: acks on the lat-th cycle of a request (lat=1 is zero-wait)
  assign bus.ack   = bus.req && (cnt >= lat - 1);
  assign bus.rdata = 32'h0000_00A0 + bus.addr;

  always_ff @(posedge clk) begin
    if (rst)                 cnt <= 0;
    else if (bus.req && bus.ack) cnt <= 0;
    else if (bus.req)        cnt <= cnt + 1;
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    int          lat;
    logic        exp_req;
    logic        chk_addr;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc4;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                     input int l, input logic rq, input logic ca, input logic [31:0] a,
                     input logic v, input logic [31:0] p, input logic [31:0] p4,
                     input logic [31:0] ins);
    vec_t x;
    x.rst = r; x.stall = s; x.redir = rd; x.rpc = rp; x.lat = l;
    x.exp_req = rq; x.chk_addr = ca; x.exp_addr = a;
    x.exp_valid = v; x.exp_pc = p; x.exp_pc4 = p4; x.exp_inst = ins;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
    end
  endtask

  initial begin
    int bubbles;
    bit got;

    // rst stall redir rpc lat | req chk addr | valid pc pc4 inst
    add(1,0,0,0,1,                 0,0,0,              0,0,0,NOP);
    add(1,0,0,0,1,                 0,0,0,              0,0,0,NOP);
    add(0,0,0,0,1,                 1,1,32'h100,        1,32'h100,32'h104,32'h1A0);
    add(0,0,0,0,1,                 1,1,32'h104,        1,32'h104,32'h108,32'h1A4);
    add(0,0,0,0,1,                 1,1,32'h108,        1,32'h108,32'h10C,32'h1A8);
    add(0,0,0,0,3,                 1,1,32'h10C,        0,32'h108,32'h10C,32'h1A8);
    add(0,0,0,0,3,                 1,1,32'h10C,        0,32'h108,32'h10C,32'h1A8);
    add(0,0,0,0,3,                 1,1,32'h10C,        1,32'h10C,32'h110,32'h1AC);
    add(0,0,0,0,3,                 1,1,32'h110,        0,32'h10C,32'h110,32'h1AC);
    add(0,0,0,0,3,                 1,1,32'h110,        0,32'h10C,32'h110,32'h1AC);
    add(0,0,0,0,3,                 1,1,32'h110,        1,32'h110,32'h114,32'h1B0);
    add(0,0,0,0,1,                 1,1,32'h114,        1,32'h114,32'h118,32'h1B4);
    add(0,1,0,0,1,                 1,1,32'h118,        1,32'h114,32'h118,32'h1B4);
    add(0,1,0,0,1,                 0,0,0,              1,32'h114,32'h118,32'h1B4);
    add(0,1,0,0,1,                 0,0,0,              1,32'h114,32'h118,32'h1B4);
    add(0,1,0,0,1,                 0,0,0,              1,32'h114,32'h118,32'h1B4);
    add(0,0,0,0,1,                 0,0,0,              1,32'h118,32'h11C,32'h1B8);
    add(0,0,0,0,1,                 1,1,32'h11C,        1,32'h11C,32'h120,32'h1BC);
    add(0,0,1,32'h203,2,           1,1,32'h120,        0,32'h11C,32'h120,32'h1BC);
    add(0,0,0,0,2,                 1,1,32'h120,        0,32'h11C,32'h120,32'h1BC);
    add(0,0,0,0,2,                 1,1,32'h200,        0,32'h11C,32'h120,32'h1BC);
    add(0,0,0,0,2,                 1,1,32'h200,        1,32'h200,32'h204,32'h2A0);
    add(0,1,1,32'h300,1,           1,1,32'h204,        0,32'h200,32'h204,32'h2A0);
    add(0,0,0,0,1,                 1,1,32'h300,        1,32'h300,32'h304,32'h3A0);
    add(0,0,1,32'h400,3,           1,1,32'h304,        0,32'h300,32'h304,32'h3A0);
    add(0,0,1,32'h500,3,           1,1,32'h304,        0,32'h300,32'h304,32'h3A0);
    add(0,0,0,0,3,                 1,1,32'h304,        0,32'h300,32'h304,32'h3A0);
    add(0,0,0,0,1,                 1,1,32'h500,        1,32'h500,32'h504,32'h5A0);
    add(0,0,1,32'hFFFF_FFFF,1,     1,1,32'h504,        0,32'h500,32'h504,32'h5A0);
    add(0,0,0,0,1,                 1,1,32'hFFFF_FFFC,  1,32'hFFFF_FFFC,32'h0,32'h9C);
    add(0,0,0,0,1,                 1,1,32'h0,          1,32'h0,32'h4,32'hA0);
    add(0,0,0,0,3,                 1,1,32'h4,          0,32'h0,32'h4,32'hA0);
    add(1,0,0,0,3,                 0,0,0,              0,0,0,NOP);
    add(0,0,0,0,1,                 1,1,32'h100,        1,32'h100,32'h104,32'h1A0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      stall          = vecs[i].stall;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      lat            = vecs[i].lat;
      #1;
      chk("imem_req", i, 32'(bus.req), 32'(vecs[i].exp_req));
      if (vecs[i].chk_addr) chk("imem_addr", i, bus.addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      chk("if_valid", i, 32'(if_valid), 32'(vecs[i].exp_valid));
      chk("if_pc",    i, if_pc,   vecs[i].exp_pc);
      chk("if_pc4",   i, if_pc4,  vecs[i].exp_pc4);
      chk("if_inst",  i, if_inst, vecs[i].exp_inst);
    end

    // 3-cycle memory: address held steady, exactly two bubbles before 0x104 arrives
    bubbles = 0;
    got     = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; lat = 3;
      #1;
      chk("hold_req",  100 + c, 32'(bus.req), 32'd1);
      chk("hold_addr", 100 + c, bus.addr, 32'h104);
      @(posedge clk);
      #1;
      if (if_valid) got = 1'b1;
      else          bubbles++;
    end
    chk("lat3_delivered", 200, 32'(got), 32'd1);
    chk("lat3_bubbles",   200, 32'(bubbles), 32'd2);
    chk("lat3_pc",        200, if_pc,   32'h104);
    chk("lat3_pc4",       200, if_pc4,  32'h108);
    chk("lat3_inst",      200, if_inst, 32'h1A4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
